mult_seq_led_board: RTL
=======================

Name: mult_seq_led_board

Overview:
Sequential shift-add multiplier board block. It performs the inverse operation of the team's sequential divider board and uses the same board I/O: an active-low start button, a done flag, one 7-segment digit and four LEDs. Operands are fixed by parameters because the board has no switches. After computing, the block scans the 2*WIDTH-bit product out one hex nibble at a time on the 7-segment digit.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and at least 8.
- OP_A, 16'd1234: multiplicand.
- OP_B, 16'd567: multiplier.
- DISP_TICKS, 50_000_000: clock cycles each nibble is shown (1 s at 50 MHz). Benches use a small value, e.g. 4.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: synchronous reset, active-low.
- start, input, 1: start button, active-low, level input.
- done, output, 1: product valid; stays high until the next launch or reset.
- out, output, 7: 7-segment pattern, active-low segments, order {g,f,e,d,c,b,a}.
- led1, output, 1: nibble index bit 0.
- led2, output, 1: nibble index bit 1.
- led3, output, 1: nibble index bit 2.
- led4, output, 1: high when the upper WIDTH bits of the product are non-zero.

Behaviour:
- One clock domain. Reset is synchronous, active-low, and applies on any rising clk edge with rst=0, including mid-calculation.
- Reset values:
  - state = IDLE, done = 0.
  - out = 7'b1111111 (blank).
  - led1..led4 = 0.
  - product = 0, nibble index = 0, tick counter = 0.
  - start_q = 1.
- Launch:
  - start is registered into start_q every cycle.
  - A launch is start==0 && start_q==1, i.e. a falling edge. Holding start low does not re-launch.
  - Launches are accepted only in IDLE or DONE. A launch during CALC is ignored.
- FSM states and transitions:
  - IDLE -> CALC on launch.
  - CALC -> DONE after WIDTH iterations.
  - DONE -> CALC on launch.
  - No other transitions.
- Launch edge E0:
  - Load acc = 0, mcand = OP_A zero-extended to 2*WIDTH bits, mplier = OP_B, iteration count = 0.
  - Clear done.
- CALC, one iteration per edge:
  - If mplier[0], acc += mcand, modulo 2^(2*WIDTH).
  - Then mcand <<= 1, mplier >>= 1.
  - At edge E_WIDTH: state = DONE, product = acc, done = 1.
  - Latency: done is high after exactly WIDTH edges following E0 (16 for the default).
- DONE display:
  - Nibble index idx runs from 0 to 2*WIDTH/4 - 1 and starts at 0 on entry to DONE.
  - idx increments after DISP_TICKS cycles and wraps from its maximum to 0.
  - out = seg7(product[4*idx +: 4]), registered.
  - {led3,led2,led1} = idx[2:0].
  - led4 = |product[2*WIDTH-1:WIDTH].
- IDLE and CALC display: out is blank and all LEDs are 0.
- Relaunch from DONE: done drops on E0, out blanks, idx and the tick counter are cleared.
- Simultaneous reset and launch: reset wins.
- Hex segment encoding: standard 0-F; A, b, C, d, E, F use the usual shapes.

Optional Feature:
Macro MULT_SIGNED_EN.
- Defined:
  - OP_A and OP_B are treated as two's complement.
  - At E0 the registers load the magnitudes, and neg = sign(A) ^ sign(B) is latched.
  - An extra FIX state follows CALC: product = neg ? -acc : acc. Latency becomes WIDTH+1.
  - led4 = product differs from the sign-extension of product[WIDTH-1:0].
- Undefined: the block is unsigned only, with no FIX state and latency WIDTH.

Decomposition:
- Package mult_seq_pkg holds:
  - the state encoding (IDLE, CALC, FIX, DONE);
  - the constants SEG_BLANK = 7'b1111111 and NIBBLES = 2*WIDTH/4 (derived from the default WIDTH);
  - the 16-entry seg7 table.
- Sub-module hex_to_seg7: a purely combinational 4-bit to 7-bit active-low decoder. It is shared with the divider board display.

Test Plan:
1. rst=0 for 1 cycle, then 1 with start held high: done=0, out=7'b1111111, LEDs=0, and nothing launches.
2. OP_A=1234, OP_B=567, start pulsed low for 1 cycle: done rises 16 edges after the sampled edge, product=0x000AAD1E, led4=0. With DISP_TICKS=4, out steps through E,1,D,A,A,0,0,0 with idx 0..7, then wraps to idx 0.
3. OP_A=OP_B=16'hFFFF: product=0xFFFE0001, led4=1, nibble 0 shows "1" and nibble 7 shows "F".
4. start held low 100 cycles: exactly one calculation. A second falling edge mid-CALC is ignored; a falling edge in DONE relaunches, with done=0 for 16 edges and the same product.
5. rst=0 at iteration 8 of CALC: next edge gives IDLE, done=0, out blank. A relaunch then produces the correct product.
6. With MULT_SIGNED_EN, OP_A=-3, OP_B=5: done after 17 edges, product=0xFFFFFFF1, led4=0.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared state encoding, display constants and hex segment table
package mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int         DEF_WIDTH = 16;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int         NIBBLES   = 2 * DEF_WIDTH / 4;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
    import mult_seq_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_TABLE[nibble_i];

endmodule

// File: rtl/mult_seq_led_board.sv
// rtl/mult_seq_led_board.sv - shift-add multiplier board with hex product scan; MULT_SIGNED_EN adds signed operands
module mult_seq_led_board
    import mult_seq_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] OP_A       = 16'd1234,
    parameter logic [WIDTH-1:0] OP_B       = 16'd567,
    parameter int               DISP_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic [6:0] out,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4
);

    localparam int          PW       = 2 * WIDTH;
    localparam int          NIB      = PW / 4;
    localparam logic [7:0]  CNT_MAX  = 8'(WIDTH - 1);
    localparam logic [7:0]  IDX_MAX  = 8'(NIB - 1);
    localparam logic [31:0] TICK_MAX = 32'(DISP_TICKS - 1);

    state_e          state_q, state_d;
    logic            start_q;
    logic            done_q, done_d;
    logic [6:0]      out_q, out_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      idx_q, idx_d;
    logic [31:0]     tick_q, tick_d;
    logic [PW-1:0]   acc_next;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic            launch;
    logic [3:0]      nib_next;
    logic [6:0]      seg_next;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;
    assign mag_a = OP_A[WIDTH-1] ? (~OP_A + 1'b1) : OP_A;
    assign mag_b = OP_B[WIDTH-1] ? (~OP_B + 1'b1) : OP_B;
`else
    assign mag_a = OP_A;
    assign mag_b = OP_B;
`endif

    assign launch   = !start && start_q;
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tick_d   = tick_q;
`ifdef MULT_SIGNED_EN
        neg_d    = neg_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d  = ST_CALC;
                    done_d   = 1'b0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    cnt_d    = '0;
                    idx_d    = '0;
                    tick_d   = '0;
`ifdef MULT_SIGNED_EN
                    neg_d    = OP_A[WIDTH-1] ^ OP_B[WIDTH-1];
`endif
                end else if (state_q == ST_DONE) begin
                    if (tick_q == TICK_MAX) begin
                        tick_d = '0;
                        idx_d  = (idx_q == IDX_MAX) ? 8'd0 : idx_q + 8'd1;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
            end
            ST_CALC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q == CNT_MAX) begin
`ifdef MULT_SIGNED_EN
                    state_d = ST_FIX;
`else
                    state_d = ST_DONE;
                    prod_d  = acc_next;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    tick_d  = '0;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            ST_FIX: begin
                state_d = ST_DONE;
                prod_d  = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d  = 1'b1;
                idx_d   = '0;
                tick_d  = '0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode the nibble that will be on display after this edge so out stays aligned with idx
    assign nib_next = 4'(prod_d >> {idx_d, 2'b00});
    assign out_d    = (state_d == ST_DONE) ? seg_next : SEG_BLANK;

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nib_next),
        .seg_o    (seg_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b1;
            done_q   <= 1'b0;
            out_q    <= SEG_BLANK;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            tick_q   <= '0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            done_q   <= done_d;
            out_q    <= out_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    logic in_done;
    logic hi_flag;

    assign in_done = (state_q == ST_DONE);
`ifdef MULT_SIGNED_EN
    assign hi_flag = prod_q != {{WIDTH{prod_q[WIDTH-1]}}, prod_q[WIDTH-1:0]};
`else
    assign hi_flag = |prod_q[PW-1:WIDTH];
`endif

    assign done = done_q;
    assign out  = out_q;
    assign led1 = in_done & idx_q[0];
    assign led2 = in_done & idx_q[1];
    assign led3 = in_done & idx_q[2];
    assign led4 = in_done & hi_flag;

endmodule
